fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-side controller for the async FIFO, running entirely in the read clock domain. It synchronizes the write-domain Gray write pointer and maintains the binary and Gray read pointers. It generates the registered empty flag and drives the shared FIFO RAM read address. Data from the RAM's combinational read port is presented to the downstream consumer through a one-entry valid/ready output register.

## Interface
- `datawidth`, 8: width of one FIFO word.
- `addr_width`, 3: RAM address width; depth = 1 << addr_width; pointers are addr_width+1 bits.

- `rclk` input 1: read clock; all state updates on its rising edge.
- `rrst` input 1: reset, synchronous to `rclk`, active-high.
- `wptr` input addr_width+1: Gray write pointer from the write domain, asynchronous to `rclk`.
- `mem_rdata` input datawidth: combinational RAM read data for `raddr`.
- `rd_ready` input 1: consumer accepts `rd_data` this cycle.
- `raddr` output addr_width: RAM read address = low addr_width bits of the binary read pointer.
- `rptr` output addr_width+1: registered Gray read pointer, sent to the write domain.
- `rempty` output 1: registered FIFO-empty flag; also drives the RAM `rempty` input.
- `rd_data` output datawidth: output register data.
- `rd_valid` output 1: `rd_data` holds an unconsumed word.

## Operation
- Synchronizer: `rq1_wptr <= wptr`, then `rq2_wptr <= rq1_wptr`. Only `rq2_wptr` is used.
- Pop condition: `rinc = ~rempty & (~rd_valid | rd_ready)`.
- Binary pointer: `rbinnext = rbin + rinc`, modulo 2^(addr_width+1), so it wraps naturally.
- Gray pointer: `rgraynext = (rbinnext >> 1) ^ rbinnext`.
- Register update each edge: `rbin <= rbinnext`, `rptr <= rgraynext`, `rempty <= (rgraynext == rq2_wptr)`.
- Output register:
  - If `rinc`: `rd_data <= mem_rdata`, `rd_valid <= 1`.
  - Else if `rd_ready`: `rd_valid <= 0`; `rd_data` holds its value.
  - Otherwise both hold.
- Reset values: `rbin`, `rptr`, `rq1_wptr`, `rq2_wptr` = 0; `rempty` = 1; `rd_valid` = 0; `rd_data` = 0. `raddr` is therefore 0.
- Reset mid-stream discards any held word and returns to empty. Reset is only meaningful when the write side is reset in the same window; the block does not coordinate this.
- Wrap-around: the pointer MSB toggles once per pass through the RAM. Empty means the full Gray pointers are equal, including the MSB.
- Simultaneous pop and consume: when `rd_valid & rd_ready & ~rempty`, a new word loads in the same edge. Throughput is one word per `rclk`.
- Last word: popping the final word sets `rempty` on that same edge, because the comparison uses `rgraynext`. No over-read can occur.
- `rempty` is pessimistic. It may stay high up to 2 edges after a write completes, and that is legal.
- It never falsely deasserts.

## Timing
- Write pointer change reaches `rempty` deassertion in three `rclk` edges:
  - edge 1: `rq1_wptr` updates;
  - edge 2: `rq2_wptr` updates;
  - edge 3: `rempty` goes to 0.
- First `rd_valid`: on edge 4, provided `rd_valid` was 0.
- `mem_rdata` is sampled in the cycle `raddr` equals the pointer being popped. `raddr` is stable from the register, so there is no combinational path from `rd_ready` to `raddr`.
- `rd_ready` combinationally affects only `rinc`, and through it the next-state logic.
- `rptr` changes at most one Gray bit per edge, which makes it safe for the write-domain synchronizer.

## Structure
- Shared package `fifo_pkg`:
  - Gray/binary conversion functions;
  - the default `datawidth` and `addr_width` constants;
  - `fifo_depth = 1 << addr_width`.
- Sub-module `sync_w2r`: a parameterized 2-flop synchronizer for the pointer (width addr_width+1, `rclk`/`rrst`). It is the mirror of the write-side `sync_r2w`.
- Everything else sits in `fifo_read_ctrl`.

## Test plan
- Reset: hold `rrst` for 2 edges with `wptr` = 4'b0110.
  - After release: `rempty`=1, `rd_valid`=0, `rptr`=0, `raddr`=0.
  - 3 edges later: `rempty`=0.
- Single word:
  - Stimulus: `wptr` 0→0001 with `mem_rdata` = 8'hA5 at `raddr` 0, `rd_ready`=1.
  - Response: `rempty` falls on edge 3; `rd_valid`=1 and `rd_data`=A5 on edge 4. On that edge `rempty`=1 and `rptr`=0001; `rd_valid`=0 on edge 5.
- Backpressure:
  - Stimulus: 3 words 11,22,33 available, `rd_ready`=0.
  - Response: `rd_valid`=1 with `rd_data`=11 held. Exactly one pop occurs (`rptr`=0001) until `rd_ready` rises. Then 22 and 33 follow on consecutive edges.
- Streaming wrap: write 20 words (values 0..19) with Gray `wptr` stepping through wrap, `rd_ready`=1.
  - Response: the read sequence is 0..19 in order with no gaps once filled.
  - `raddr` wraps 7→0 twice; the `rbin` MSB toggles at words 8 and 16.
  - Final `rptr` = Gray(20 mod 16) = 0110; `rempty`=1.
- Mid-stream reset: assert `rrst` while `rd_valid`=1 and 2 words pending.
  - Response: the next edge gives `rd_valid`=0, `rempty`=1, `rptr`=0, `rd_data`=0.
- Random `rd_ready` against a scoreboard:
  - No duplicate or lost words.
  - `rinc` is never asserted while `rempty`=1.
  - `rptr` has Hamming distance ≤1 per edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary helpers.
// Helpers work on 32-bit values; callers size-cast to their pointer width.
package fifo_pkg;

  localparam int fifo_datawidth  = 8;
  localparam int fifo_addr_width = 3;
  localparam int fifo_depth      = 1 << fifo_addr_width;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer bringing the write-domain Gray pointer into rclk.
// Ports: rclk/rrst (sync, active-high), wptr (async Gray in),
//        rq2_wptr (synchronized Gray out).
module sync_w2r #(
  parameter int width = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [width-1:0] wptr,
  output logic [width-1:0] rq2_wptr
);

  logic [width-1:0] rq1_wptr;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= wptr;
      rq2_wptr <= rq1_wptr;
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller (rclk domain).
// Ports: rclk/rrst (sync, active-high); wptr (write Gray pointer, async);
//        mem_rdata (combinational RAM data at raddr); rd_ready (consumer);
//        raddr (RAM read address); rptr (Gray read pointer to write side);
//        rempty (registered empty); rd_data/rd_valid (one-entry output reg).
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int datawidth  = fifo_datawidth,
  parameter int addr_width = fifo_addr_width
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [addr_width:0]   wptr,
  input  logic [datawidth-1:0]  mem_rdata,
  input  logic                  rd_ready,
  output logic [addr_width-1:0] raddr,
  output logic [addr_width:0]   rptr,
  output logic                  rempty,
  output logic [datawidth-1:0]  rd_data,
  output logic                  rd_valid
);

  localparam int PW = addr_width + 1;

  logic [addr_width:0] rbin, rbinnext, rgraynext, rq2_wptr;
  logic                rinc;

  sync_w2r #(.width(PW)) u_sync (
    .rclk     (rclk),
    .rrst     (rrst),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  // Pop when a word exists and the output slot is free or being drained.
  assign rinc      = ~rempty & (~rd_valid | rd_ready);
  assign rbinnext  = rbin + {{addr_width{1'b0}}, rinc};
  assign rgraynext = PW'(bin2gray(32'(rbinnext)));
  assign raddr     = rbin[addr_width-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      // Compare the post-pop pointer so the last pop flags empty immediately.
      rempty <= (rgraynext == rq2_wptr);
      if (rinc) begin
        rd_data  <= mem_rdata;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [AW:0]   wptr = '0;
  logic [DW-1:0] mem_rdata;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] sb [$];
  logic [AW:0]   wbin = '0;
  int passed = 0;
  int total  = 0;

  always #5 rclk = ~rclk;
  assign mem_rdata = mem[raddr];

  fifo_read_ctrl #(.datawidth(DW), .addr_width(AW)) dut (
    .rclk(rclk), .rrst(rrst), .wptr(wptr), .mem_rdata(mem_rdata),
    .rd_ready(rd_ready), .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  function automatic logic [AW:0] g(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] gv);
    logic [AW:0] b;
    b[AW] = gv[AW];
    for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ gv[i];
    return b;
  endfunction

  task automatic tick;
    @(posedge rclk); #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    mem[wbin[AW-1:0]] = v;
    sb.push_back(v);
    wbin = wbin + 1'b1;
    wptr = g(wbin);
  endtask

  task automatic do_reset;
    rrst = 1'b1; rd_ready = 1'b0; wptr = '0; wbin = '0; sb.delete();
    tick; tick;
    rrst = 1'b0;
  endtask

  task automatic test_reset;
    rd_ready = 1'b0; rrst = 1'b1; wptr = 4'b0110;
    tick; tick;
    rrst = 1'b0;
    total++; if (rempty !== 1'b1) $display("FAIL rst_empty got %b want 1", rempty); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rd_valid); else passed++;
    total++; if (rptr !== 4'b0000) $display("FAIL rst_rptr got %b want 0000", rptr); else passed++;
    total++; if (raddr !== 3'd0) $display("FAIL rst_raddr got %0d want 0", raddr); else passed++;
    tick; tick;
    total++; if (rempty !== 1'b1) $display("FAIL rst_empty_e2 got %b want 1", rempty); else passed++;
    tick;
    total++; if (rempty !== 1'b0) $display("FAIL rst_empty_e3 got %b want 0", rempty); else passed++;
  endtask

  task automatic test_single_word;
    logic [DW-1:0] exp;
    do_reset;
    rd_ready = 1'b1;
    write_word(8'hA5);
    tick; tick;
    total++; if (rempty !== 1'b1) $display("FAIL sw_empty_e2 got %b want 1", rempty); else passed++;
    tick;
    total++; if (rempty !== 1'b0) $display("FAIL sw_empty_e3 got %b want 0", rempty); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL sw_valid_e3 got %b want 0", rd_valid); else passed++;
    tick;
    total++; if (rd_valid !== 1'b1) $display("FAIL sw_valid_e4 got %b want 1", rd_valid); else passed++;
    total++; if (rempty !== 1'b1) $display("FAIL sw_empty_e4 got %b want 1", rempty); else passed++;
    total++; if (rptr !== 4'b0001) $display("FAIL sw_rptr got %b want 0001", rptr); else passed++;
    exp = sb.pop_front();
    total++; if (rd_data !== exp) $display("FAIL sw_data got %h want %h", rd_data, exp); else passed++;
    tick;
    total++; if (rd_valid !== 1'b0) $display("FAIL sw_valid_e5 got %b want 0", rd_valid); else passed++;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp;
    do_reset;
    write_word(8'h11); write_word(8'h22); write_word(8'h33);
    repeat (8) tick;
    total++; if (rd_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", rd_valid); else passed++;
    total++; if (rptr !== 4'b0001) $display("FAIL bp_rptr_hold got %b want 0001", rptr); else passed++;
    total++; if (rd_data !== sb[0]) $display("FAIL bp_data_hold got %h want %h", rd_data, sb[0]); else passed++;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (rptr !== g(4'(i+1))) $display("FAIL bp_rptr%0d got %b want %b", i, rptr, g(4'(i+1))); else passed++;
      exp = sb.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL bp_data%0d got %b/%h want 1/%h", i, rd_valid, rd_data, exp); else passed++;
      tick;
    end
    total++; if (rd_valid !== 1'b0) $display("FAIL bp_valid_end got %b want 0", rd_valid); else passed++;
    total++; if (rempty !== 1'b1) $display("FAIL bp_empty_end got %b want 1", rempty); else passed++;
  endtask

  // Writer + consumer loop against the scoreboard, with per-edge pointer checks.
  task automatic run_stream(input int n, input bit rnd, output int wraps, output int msb_tog, output int span);
    int written = 0, got = 0, cyc = 0, first = -1, last = 0;
    logic [AW:0] prv_rptr, rb;
    logic prv_empty;
    logic [AW-1:0] prv_raddr;
    logic [DW-1:0] exp;
    wraps = 0; msb_tog = 0; span = 0;
    while ((written < n || sb.size() != 0) && cyc < 3000) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL st_extra got %h want none", rd_data);
        else begin
          exp = sb.pop_front();
          if (rd_data !== exp) $display("FAIL st_data got %h want %h", rd_data, exp); else passed++;
        end
        if (first < 0) first = cyc;
        last = cyc; got++;
      end
      if (written < n && 4'(wbin - g2b(rptr)) < 4'd8) begin
        write_word(8'(written));
        written++;
      end
      prv_rptr = rptr; prv_empty = rempty; prv_raddr = raddr;
      tick; cyc++;
      total++; if ($countones(prv_rptr ^ rptr) > 1) $display("FAIL st_gray got %b want 1-bit step from %b", rptr, prv_rptr); else passed++;
      total++; if (prv_empty && rptr !== prv_rptr) $display("FAIL st_pop_empty got %b want %b", rptr, prv_rptr); else passed++;
      rb = g2b(rptr);
      total++; if (raddr !== rb[AW-1:0]) $display("FAIL st_raddr got %0d want %0d", raddr, rb[AW-1:0]); else passed++;
      if (prv_raddr == 3'd7 && raddr == 3'd0) wraps++;
      if (prv_rptr[AW] != rptr[AW]) msb_tog++;
    end
    total++; if (cyc >= 3000) $display("FAIL st_timeout got %0d cycles want <3000", cyc); else passed++;
    total++; if (got != n) $display("FAIL st_count got %0d want %0d", got, n); else passed++;
    span = last - first + 1;
  endtask

  task automatic test_stream_wrap;
    int wraps, tog, span;
    do_reset;
    run_stream(20, 1'b0, wraps, tog, span);
    total++; if (wraps != 2) $display("FAIL wr_raddr_wraps got %0d want 2", wraps); else passed++;
    total++; if (tog != 2) $display("FAIL wr_msb_toggles got %0d want 2", tog); else passed++;
    total++; if (span != 20) $display("FAIL wr_no_gaps got %0d want 20", span); else passed++;
    total++; if (rptr !== 4'b0110) $display("FAIL wr_rptr got %b want 0110", rptr); else passed++;
    total++; if (rempty !== 1'b1) $display("FAIL wr_empty got %b want 1", rempty); else passed++;
  endtask

  task automatic test_mid_reset;
    do_reset;
    write_word(8'h5A); write_word(8'h6B); write_word(8'h7C);
    repeat (6) tick;
    total++; if (rd_valid !== 1'b1) $display("FAIL mr_pre_valid got %b want 1", rd_valid); else passed++;
    rrst = 1'b1;
    tick;
    total++; if (rd_valid !== 1'b0) $display("FAIL mr_valid got %b want 0", rd_valid); else passed++;
    total++; if (rempty !== 1'b1) $display("FAIL mr_empty got %b want 1", rempty); else passed++;
    total++; if (rptr !== 4'b0000) $display("FAIL mr_rptr got %b want 0000", rptr); else passed++;
    total++; if (rd_data !== 8'h00) $display("FAIL mr_data got %h want 00", rd_data); else passed++;
    total++; if (raddr !== 3'd0) $display("FAIL mr_raddr got %0d want 0", raddr); else passed++;
    do_reset;
  endtask

  task automatic test_random_ready;
    int wraps, tog, span;
    do_reset;
    run_stream(60, 1'b1, wraps, tog, span);
    total++; if (rptr !== g(4'(60))) $display("FAIL rnd_rptr got %b want %b", rptr, g(4'(60))); else passed++;
    total++; if (rempty !== 1'b1) $display("FAIL rnd_empty got %b want 1", rempty); else passed++;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    test_reset;
    test_single_word;
    test_backpressure;
    test_stream_wrap;
    test_mid_reset;
    test_random_ready;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
